// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  mdu_pkg : MDU op codes, default latencies and op-class helpers
//  Rev 1.0
// ============================================================================
package mdu_pkg;

    typedef logic [3:0] mdu_op_t;

    localparam mdu_op_t MDU_NONE  = 4'b0000;
    localparam mdu_op_t MDU_MULT  = 4'b0001;
    localparam mdu_op_t MDU_MULTU = 4'b0010;
    localparam mdu_op_t MDU_DIV   = 4'b0011;
    localparam mdu_op_t MDU_DIVU  = 4'b0100;
    localparam mdu_op_t MDU_MFHI  = 4'b0101;
    localparam mdu_op_t MDU_MFLO  = 4'b0110;
    localparam mdu_op_t MDU_MTHI  = 4'b0111;
    localparam mdu_op_t MDU_MTLO  = 4'b1000;

    localparam int MULT_LAT_DEFAULT = 5;
    localparam int DIV_LAT_DEFAULT  = 10;
    localparam int CNT_W            = 4;

    function automatic logic is_mult(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_start_op(input mdu_op_t op);
        return is_mult(op) || is_div(op);
    endfunction

    // Codes outside 1..8 behave exactly like NONE.
    function automatic logic is_mdu_op(input mdu_op_t op);
        return (op >= MDU_MULT) && (op <= MDU_MTLO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu_issue_if.sv
`default_nettype none
// ============================================================================
//  e_mdu_issue_if : D-side request / E-side MDU drive bundle
//  Rev 1.0
// ============================================================================
interface e_mdu_issue_if;
    import mdu_pkg::*;

    logic        req;
    logic        d_valid;
    mdu_op_t     d_mdu_op;
    logic [31:0] d_rs;
    logic [31:0] d_rt;
    logic        mdu_busy;
    logic        stall_d;
    logic        e_start;
    mdu_op_t     e_mdu_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_is_mfhilo;
    logic        busy_err;

    modport slave (
        input  req, d_valid, d_mdu_op, d_rs, d_rt, mdu_busy,
        output stall_d, e_start, e_mdu_op, e_a, e_b, e_is_mfhilo, busy_err
    );

    modport master (
        output req, d_valid, d_mdu_op, d_rs, d_rt, mdu_busy,
        input  stall_d, e_start, e_mdu_op, e_a, e_b, e_is_mfhilo, busy_err
    );

endinterface
`default_nettype wire

// File: rtl/mdu_shadow_cnt.sv
`default_nettype none
// ============================================================================
//  mdu_shadow_cnt : shadow latency counter mirroring MDU Busy, sticky mismatch
//  Rev 1.0
// ============================================================================
module mdu_shadow_cnt
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             req,
    input  wire logic             start,
    input  wire mdu_op_t          start_op,
    input  wire logic             mdu_busy,
    output logic [CNT_W-1:0]      cnt,
    output logic                  busy_err
);

    localparam logic [CNT_W-1:0] C_MULT_LAT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] C_DIV_LAT  = CNT_W'(DIV_LAT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy_err;

    // The MDU freezes on req, so the counter and the check both pause with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_busy_err <= 1'b0;
        end else if (!req) begin
            if (start && is_mult(start_op)) begin
                r_cnt <= C_MULT_LAT;
            end else if (start && is_div(start_op)) begin
                r_cnt <= C_DIV_LAT;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (!start && ((r_cnt != '0) != mdu_busy)) begin
                r_busy_err <= 1'b1;
            end
        end
    end

    assign cnt      = r_cnt;
    assign busy_err = r_busy_err;

endmodule
`default_nettype wire

// File: rtl/e_mdu_issue.sv
`default_nettype none
// ============================================================================
//  e_mdu_issue : D->E issue register for the MDU with busy stall generation
//  Rev 1.0
// ============================================================================
module e_mdu_issue
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     reset,
    e_mdu_issue_if.slave  bus
);

    logic             r_start;
    mdu_op_t          r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;

    logic [CNT_W-1:0] w_cnt;
    logic             w_busy_err;
    logic             w_d_mdu;
    logic             w_busy_pred;
    logic             w_stall;

    assign w_d_mdu     = bus.d_valid && is_mdu_op(bus.d_mdu_op);
    assign w_busy_pred = (w_cnt != '0) || r_start;
    assign w_stall     = !reset && w_d_mdu && (w_busy_pred || bus.mdu_busy);

    always_ff @(posedge clk) begin
        if (reset || bus.req || w_stall) begin
            r_start <= 1'b0;
            r_op    <= MDU_NONE;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_start <= bus.d_valid && is_start_op(bus.d_mdu_op);
            r_op    <= w_d_mdu ? bus.d_mdu_op : MDU_NONE;
            r_a     <= bus.d_rs;
            r_b     <= bus.d_rt;
        end
    end

    mdu_shadow_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.req),
        .start    (r_start),
        .start_op (r_op),
        .mdu_busy (bus.mdu_busy),
        .cnt      (w_cnt),
        .busy_err (w_busy_err)
    );

    assign bus.stall_d     = w_stall;
    assign bus.e_start     = r_start;
    assign bus.e_mdu_op    = r_op;
    assign bus.e_a         = r_a;
    assign bus.e_b         = r_b;
    assign bus.e_is_mfhilo = (r_op == MDU_MFHI) || (r_op == MDU_MFLO);
    assign bus.busy_err    = w_busy_err;

endmodule
`default_nettype wire

// File: tb/tb_e_mdu_issue.sv
`default_nettype none
// ============================================================================
//  tb_e_mdu_issue : directed table, corner sequences and random traffic
//  Rev 1.0
// ============================================================================
module tb_e_mdu_issue;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    e_mdu_issue_if bus();

    e_mdu_issue #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: the unit is free from absolute cycle free_at onwards.
    int          now = 0;
    int          free_at = 0;
    logic        m_start = 1'b0;
    mdu_op_t     m_op = 4'd0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic        m_err = 1'b0;
    logic        inject = 1'b0;

    typedef struct {
        logic        rst, rq, dv;
        mdu_op_t     op;
        logic [31:0] rs, rt;
        logic        x_stall, x_start;
        mdu_op_t     x_op;
        logic [31:0] x_a, x_b;
        logic        x_mf;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input logic rst, rq, dv, input mdu_op_t op,
                                input logic [31:0] rs, rt,
                                input logic xs, xst, input mdu_op_t xop,
                                input logic [31:0] xa, xb, input logic xmf);
        vec_t v;
        v.rst = rst; v.rq = rq; v.dv = dv; v.op = op; v.rs = rs; v.rt = rt;
        v.x_stall = xs; v.x_start = xst; v.x_op = xop; v.x_a = xa; v.x_b = xb; v.x_mf = xmf;
        return v;
    endfunction

    function automatic logic legal(input mdu_op_t op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic int lat(input mdu_op_t op);
        return (op == 4'd1 || op == 4'd2) ? 5 : 10;
    endfunction

    function automatic logic model_busy();
        return !m_start && (now < free_at);
    endfunction

    function automatic logic exp_stall();
        return !reset && bus.d_valid && legal(bus.d_mdu_op) && (now < free_at);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, now);
        end
    endtask

    task automatic check_all();
        chk("stall_d",     32'(bus.stall_d),     32'(exp_stall()));
        chk("e_start",     32'(bus.e_start),     32'(m_start));
        chk("e_mdu_op",    32'(bus.e_mdu_op),    32'(m_op));
        chk("e_a",         bus.e_a,              m_a);
        chk("e_b",         bus.e_b,              m_b);
        chk("e_is_mfhilo", 32'(bus.e_is_mfhilo), 32'(m_op == 4'd5 || m_op == 4'd6));
        chk("busy_err",    32'(bus.busy_err),    32'(m_err));
    endtask

    task automatic drive(input logic rst, rq, dv, input mdu_op_t op, input logic [31:0] rs, rt);
        @(negedge clk);
        reset = rst; bus.req = rq; bus.d_valid = dv; bus.d_mdu_op = op;
        bus.d_rs = rs; bus.d_rt = rt;
        #1;
    endtask

    task automatic clock_edge();
        logic stl, busy_seen, cnt_nz;
        @(posedge clk);
        stl       = exp_stall();
        busy_seen = bus.mdu_busy;
        cnt_nz    = model_busy();
        if (reset) begin
            m_start = 0; m_op = 0; m_a = 0; m_b = 0; m_err = 0; free_at = 0;
        end else if (bus.req) begin
            if (cnt_nz) free_at++;
            m_start = 0; m_op = 0; m_a = 0; m_b = 0;
        end else begin
            if (!m_start && (cnt_nz != busy_seen)) m_err = 1;
            if (m_start) free_at = now + 1 + lat(m_op);
            if (stl) begin
                m_start = 0; m_op = 0; m_a = 0; m_b = 0;
            end else begin
                m_op    = (bus.d_valid && legal(bus.d_mdu_op)) ? bus.d_mdu_op : 4'd0;
                m_a     = bus.d_rs;
                m_b     = bus.d_rt;
                m_start = bus.d_valid && bus.d_mdu_op >= 4'd1 && bus.d_mdu_op <= 4'd4;
            end
        end
        now++;
        if (m_start) free_at = now + 1;
        #1 bus.mdu_busy = model_busy() ^ inject;
    endtask

    task automatic cyc(input logic rst, rq, dv, input mdu_op_t op, input logic [31:0] rs, rt);
        drive(rst, rq, dv, op, rs, rt);
        check_all();
        clock_edge();
    endtask

    task automatic issue_wait(input mdu_op_t op, input logic [31:0] rs, rt, output int stalls);
        bit done;
        done = 0;
        stalls = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            drive(1'b0, 1'b0, 1'b1, op, rs, rt);
            check_all();
            if (bus.stall_d) stalls++;
            else done = 1;
            clock_edge();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL issue_wait timeout: op %0d still stalled after 40 cycles", op);
        end
    endtask

    initial begin
        int st;
        reset = 1'b1; bus.req = 0; bus.d_valid = 0; bus.d_mdu_op = 0;
        bus.d_rs = 0; bus.d_rt = 0; bus.mdu_busy = 0;
        clock_edge();

        // Reset hold, then MULT 3 * -2 followed by MFLO
        tbl[0]  = mk(1,0,1,MDU_MULT, 0, 0,                0,0,MDU_NONE,0,0,0);
        tbl[1]  = mk(1,0,1,MDU_MULT, 0, 0,                0,0,MDU_NONE,0,0,0);
        tbl[2]  = mk(0,0,1,MDU_MULT, 3, 32'hFFFF_FFFE,    0,0,MDU_NONE,0,0,0);
        tbl[3]  = mk(0,0,1,MDU_MFLO, 0, 0,                1,1,MDU_MULT,3,32'hFFFF_FFFE,0);
        for (int i = 4; i <= 8; i++)
            tbl[i] = mk(0,0,1,MDU_MFLO, 0, 0,             1,0,MDU_NONE,0,0,0);
        tbl[9]  = mk(0,0,1,MDU_MFLO, 0, 0,                0,0,MDU_NONE,0,0,0);
        tbl[10] = mk(0,0,0,MDU_NONE, 7, 9,                0,0,MDU_MFLO,0,0,1);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rst, tbl[i].rq, tbl[i].dv, tbl[i].op, tbl[i].rs, tbl[i].rt);
            check_all();
            chk($sformatf("tbl%0d stall_d", i), 32'(bus.stall_d), 32'(tbl[i].x_stall));
            chk($sformatf("tbl%0d e_start", i), 32'(bus.e_start), 32'(tbl[i].x_start));
            chk($sformatf("tbl%0d e_mdu_op", i), 32'(bus.e_mdu_op), 32'(tbl[i].x_op));
            chk($sformatf("tbl%0d e_a", i), bus.e_a, tbl[i].x_a);
            chk($sformatf("tbl%0d e_b", i), bus.e_b, tbl[i].x_b);
            chk($sformatf("tbl%0d e_is_mfhilo", i), 32'(bus.e_is_mfhilo), 32'(tbl[i].x_mf));
            clock_edge();
        end

        // DIVU then MULTU back to back, then MFHI waits out the MULTU
        issue_wait(MDU_DIVU, 100, 7, st);
        chk("divu stalls", 32'(st), 32'd0);
        issue_wait(MDU_MULTU, 5, 6, st);
        chk("multu stalls", 32'(st), 32'd11);
        drive(0, 0, 0, MDU_NONE, 0, 0);
        check_all();
        chk("multu e_start", 32'(bus.e_start), 32'd1);
        chk("multu e_mdu_op", 32'(bus.e_mdu_op), 32'(MDU_MULTU));
        clock_edge();
        issue_wait(MDU_MFHI, 0, 0, st);
        chk("mfhi after multu stalls", 32'(st), 32'd5);

        // req on the would-be issue edge of DIV
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, MDU_NONE, 0, 0);
        cyc(0, 1, 1, MDU_DIV, 11, 22);
        drive(0, 0, 1, MDU_MFHI, 0, 0);
        check_all();
        chk("req div e_start", 32'(bus.e_start), 32'd0);
        chk("req div e_mdu_op", 32'(bus.e_mdu_op), 32'(MDU_NONE));
        chk("req div no stall", 32'(bus.stall_d), 32'd0);
        clock_edge();

        // req held 3 cycles while cnt=4 freezes the countdown
        issue_wait(MDU_MULT, 1, 2, st);
        cyc(0, 0, 0, MDU_NONE, 0, 0);
        cyc(0, 0, 0, MDU_NONE, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, MDU_MTHI, 0, 0);
            check_all();
            chk("req freeze stall", 32'(bus.stall_d), 32'd1);
            clock_edge();
        end
        issue_wait(MDU_MTHI, 9, 0, st);
        chk("post-req stalls", 32'(st), 32'd4);
        chk("post-req busy_err", 32'(bus.busy_err), 32'd0);

        // mdu_busy dropped while cnt=2
        issue_wait(MDU_MULT, 4, 4, st);
        cyc(0, 0, 0, MDU_NONE, 0, 0);
        cyc(0, 0, 0, MDU_NONE, 0, 0);
        cyc(0, 0, 0, MDU_NONE, 0, 0);
        inject = 1'b1;
        cyc(0, 0, 0, MDU_NONE, 0, 0);
        inject = 1'b0;
        cyc(0, 0, 0, MDU_NONE, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, MDU_NONE, 0, 0);
            check_all();
            chk("busy_err sticky", 32'(bus.busy_err), 32'd1);
            clock_edge();
        end
        cyc(1, 0, 0, MDU_NONE, 0, 0);
        drive(0, 0, 0, MDU_NONE, 0, 0);
        check_all();
        chk("busy_err cleared", 32'(bus.busy_err), 32'd0);
        clock_edge();

        // Random traffic against the reference
        for (int i = 0; i < 1500; i++) begin
            logic    r_rst, r_rq, r_dv;
            mdu_op_t r_op;
            r_rst = ($urandom_range(0, 99) == 0);
            r_rq  = ($urandom_range(0, 11) == 0);
            r_dv  = ($urandom_range(0, 3) != 0);
            r_op  = ($urandom_range(0, 7) == 0) ? mdu_op_t'($urandom_range(0, 15))
                                                 : mdu_op_t'($urandom_range(0, 8));
            cyc(r_rst, r_rq, r_dv, r_op, $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
